// File: rtl/u_rx_frame_ctrl.sv
// Receive-side frame controller: parses SOF, LEN, payload, CHK frames from the UART
// byte receiver and releases the payload to the host only once the checksum passes.
module u_rx_frame_ctrl #(
  parameter int          MAX_LEN     = 16,
  parameter logic [7:0]  SOF_BYTE    = 8'hA5,
  parameter logic [15:0] TIMEOUT_CYC = 16'd4000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_l,
  input  logic [7:0] rec_dataH,
  input  logic       rec_readyH,
  output logic [7:0] out_dataH,
  output logic       out_validH,
  output logic       out_lastH,
  input  logic       out_readyH,
  output logic       busyH,
  output logic       err_chkH,
  output logic       err_lenH,
  output logic       err_toH,
  output logic       err_ovrH
);

  localparam int PW = $clog2(MAX_LEN);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StLen     = 3'd1,
    StPayload = 3'd2,
    StCheck   = 3'd3,
    StDeliver = 3'd4
  } stateT;

  stateT         state, stateNext;
  logic          readyQ, arm, byteStb;
  logic          inFrame, lenOk, timerExpired;
  logic [15:0]   timer;
  logic [7:0]    chk, chkNext;
  logic [PW-1:0] wrPtr, wrPtrNext, rdPtr, rdPtrNext, rdPtrInc;
  logic [PW-1:0] lastIdx, lastIdxNext;
  logic          memWe;
  logic [7:0]    mem [MAX_LEN];
  logic [7:0]    outDataNext;
  logic          outValidNext, outLastNext;
  logic          errChkNext, errLenNext, errToNext, errOvrNext;

  assign byteStb      = rec_readyH & ~readyQ & arm;
  assign inFrame      = (state == StLen) || (state == StPayload) || (state == StCheck);
  assign lenOk        = (rec_dataH != 8'd0) && (32'(rec_dataH) <= 32'(MAX_LEN));
  assign timerExpired = (timer == TIMEOUT_CYC - 16'd1);
  assign rdPtrInc     = rdPtr + PW'(1);
  assign busyH        = (state != StIdle);

  // arm stays low until the receiver has been seen idle-high once, hiding its power-up edge
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      readyQ <= 1'b0;
      arm    <= 1'b0;
    end else begin
      readyQ <= rec_readyH;
      arm    <= arm | rec_readyH;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) state <= StIdle;
    else            state <= stateNext;
  end

  always_comb begin
    stateNext    = state;
    chkNext      = chk;
    wrPtrNext    = wrPtr;
    rdPtrNext    = rdPtr;
    lastIdxNext  = lastIdx;
    memWe        = 1'b0;
    outDataNext  = out_dataH;
    outValidNext = out_validH;
    outLastNext  = out_lastH;
    errChkNext   = 1'b0;
    errLenNext   = 1'b0;
    errToNext    = 1'b0;
    errOvrNext   = 1'b0;
    case (state)
      StIdle: begin
        if (byteStb && (rec_dataH == SOF_BYTE)) begin
          stateNext = StLen;
          chkNext   = 8'd0;
        end
      end
      StLen: begin
        if (byteStb) begin
          if (!lenOk) begin
            errLenNext = 1'b1;
            stateNext  = StIdle;
          end else begin
            lastIdxNext = PW'(rec_dataH - 8'd1);
            chkNext     = rec_dataH;
            wrPtrNext   = '0;
            stateNext   = StPayload;
          end
        end
      end
      StPayload: begin
        if (byteStb) begin
          memWe   = 1'b1;
          chkNext = chk ^ rec_dataH;
          if (wrPtr == lastIdx) stateNext = StCheck;
          else                  wrPtrNext = wrPtr + PW'(1);
        end
      end
      StCheck: begin
        if (byteStb) begin
          if (rec_dataH == chk) begin
            stateNext    = StDeliver;
            rdPtrNext    = '0;
            outValidNext = 1'b1;
            outDataNext  = mem[0];
            outLastNext  = (lastIdx == '0);
          end else begin
            errChkNext = 1'b1;
            stateNext  = StIdle;
          end
        end
      end
      StDeliver: begin
        errOvrNext = byteStb;
        if (out_validH && out_readyH) begin
          if (out_lastH) begin
            outValidNext = 1'b0;
            outLastNext  = 1'b0;
            stateNext    = StIdle;
          end else begin
            rdPtrNext   = rdPtrInc;
            outDataNext = mem[rdPtrInc];
            outLastNext = (rdPtrInc == lastIdx);
          end
        end
      end
      default: stateNext = StIdle;
    endcase
    // A byte landing on the expiry cycle takes priority over the timeout
    if (inFrame && !byteStb && timerExpired) begin
      stateNext = StIdle;
      errToNext = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      chk        <= 8'd0;
      wrPtr      <= '0;
      rdPtr      <= '0;
      lastIdx    <= '0;
      timer      <= 16'd0;
      out_dataH  <= 8'd0;
      out_validH <= 1'b0;
      out_lastH  <= 1'b0;
      err_chkH   <= 1'b0;
      err_lenH   <= 1'b0;
      err_toH    <= 1'b0;
      err_ovrH   <= 1'b0;
    end else begin
      chk        <= chkNext;
      wrPtr      <= wrPtrNext;
      rdPtr      <= rdPtrNext;
      lastIdx    <= lastIdxNext;
      out_dataH  <= outDataNext;
      out_validH <= outValidNext;
      out_lastH  <= outLastNext;
      err_chkH   <= errChkNext;
      err_lenH   <= errLenNext;
      err_toH    <= errToNext;
      err_ovrH   <= errOvrNext;
      if (!inFrame || byteStb)  timer <= 16'd0;
      else if (timer != 16'hFFFF) timer <= timer + 16'd1;
    end
  end

  // Payload buffer holds no reset; a rejected frame is simply overwritten by the next one
  always_ff @(posedge sys_clk) begin
    if (memWe) mem[wrPtr] <= rec_dataH;
  end

endmodule

// File: tb/tb_u_rx_frame_ctrl.sv
// Self-checking bench for u_rx_frame_ctrl: directed boundary cases plus random frames
// compared against a frame-level model of expected payload and error counts.
module tb_u_rx_frame_ctrl;

  localparam int         MaxLen     = 16;
  localparam logic [7:0] Sof        = 8'hA5;
  localparam int         TimeoutCyc = 4000;

  logic       sys_clk;
  logic       sys_rst_l;
  logic [7:0] rec_dataH;
  logic       rec_readyH;
  logic [7:0] out_dataH;
  logic       out_validH;
  logic       out_lastH;
  logic       out_readyH;
  logic       busyH;
  logic       err_chkH;
  logic       err_lenH;
  logic       err_toH;
  logic       err_ovrH;

  int assertCount = 0;
  int failCount   = 0;

  logic [7:0] txQ[$];
  logic [8:0] expQ[$];
  logic [8:0] gotQ[$];
  int expChk = 0, expLen = 0, expTo = 0, expOvr = 0;
  int gotChk = 0, gotLen = 0, gotTo = 0, gotOvr = 0;

  logic       prevStall;
  logic [7:0] prevData;
  logic [3:0] prevErr;
  logic [3:0] errVec;

  u_rx_frame_ctrl #(
    .MAX_LEN    (MaxLen),
    .SOF_BYTE   (Sof),
    .TIMEOUT_CYC(16'(TimeoutCyc))
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_l (sys_rst_l),
    .rec_dataH (rec_dataH),
    .rec_readyH(rec_readyH),
    .out_dataH (out_dataH),
    .out_validH(out_validH),
    .out_lastH (out_lastH),
    .out_readyH(out_readyH),
    .busyH     (busyH),
    .err_chkH  (err_chkH),
    .err_lenH  (err_lenH),
    .err_toH   (err_toH),
    .err_ovrH  (err_ovrH)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Monitor: collects delivered beats and error pulses, checks hold-stability and pulse shape
  initial begin
    prevStall = 1'b0;
    prevErr   = 4'd0;
    prevData  = 8'd0;
    forever begin
      @(negedge sys_clk);
      errVec = {err_chkH, err_lenH, err_toH, err_ovrH};
      if (!sys_rst_l) begin
        prevStall = 1'b0;
        prevErr   = 4'd0;
      end else begin
        if (prevStall && out_validH) checkOutput("holdData", 32'(out_dataH), 32'(prevData));
        if (out_validH && out_readyH) gotQ.push_back({out_lastH, out_dataH});
        if (errVec != 4'd0) begin
          checkOutput("errOneHot", 32'($countones(errVec)), 1);
          checkOutput("errWidth", 32'(errVec & prevErr), 0);
        end
        if (err_chkH) gotChk++;
        if (err_lenH) gotLen++;
        if (err_toH)  gotTo++;
        if (err_ovrH) gotOvr++;
        prevStall = out_validH && !out_readyH;
        prevData  = out_dataH;
        prevErr   = errVec;
      end
    end
  end

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  // One UART byte: ready dips low then rises; the DUT strobes on the third edge
  task automatic applyStimulus(input logic [7:0] data);
    @(posedge sys_clk); #1;
    rec_readyH = 1'b0;
    rec_dataH  = data;
    @(posedge sys_clk); #1;
    rec_readyH = 1'b1;
    @(posedge sys_clk); #1;
  endtask

  task automatic sendTx(input bit jitter);
    foreach (txQ[i]) begin
      if (jitter) idleCycles(int'($urandom_range(0, 3)));
      applyStimulus(txQ[i]);
    end
  endtask

  task automatic waitIdle(input bit randReady);
    for (int i = 0; i < 2000 && busyH; i++) begin
      if (randReady) out_readyH = ($urandom_range(0, 3) != 0);
      idleCycles(1);
    end
    checkOutput("drainBusy", 32'(busyH), 0);
    idleCycles(2);
  endtask

  task automatic checkFrame();
    checkOutput("nBytes", 32'(gotQ.size()), 32'(expQ.size()));
    for (int i = 0; i < expQ.size() && i < gotQ.size(); i++)
      checkOutput("payload", 32'(gotQ[i]), 32'(expQ[i]));
    checkOutput("errChkCnt", 32'(gotChk), 32'(expChk));
    checkOutput("errLenCnt", 32'(gotLen), 32'(expLen));
    checkOutput("errToCnt",  32'(gotTo),  32'(expTo));
    checkOutput("errOvrCnt", 32'(gotOvr), 32'(expOvr));
    gotQ.delete();
    expQ.delete();
  endtask

  // kind 0: good frame, 1: corrupted checksum, 2: illegal LEN (n is the LEN byte)
  task automatic buildFrame(input int kind, input int n);
    logic [7:0] b;
    logic [7:0] x;
    logic [7:0] pl[$];
    txQ.delete();
    repeat ($urandom_range(0, 2)) begin
      b = Sof;
      while (b == Sof) b = 8'($urandom);
      txQ.push_back(b);
    end
    txQ.push_back(Sof);
    txQ.push_back(8'(n));
    if (kind == 2) begin
      expLen++;
      return;
    end
    x = 8'(n);
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      pl.push_back(b);
      txQ.push_back(b);
      x = x ^ b;
    end
    if (kind == 0) begin
      txQ.push_back(x);
      for (int i = 0; i < n; i++) expQ.push_back({(i == n - 1), pl[i]});
    end else begin
      txQ.push_back(x ^ 8'($urandom_range(1, 255)));
      expChk++;
    end
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int kind;
    int n;
    int r;
    sys_rst_l  = 1'b0;
    rec_readyH = 1'b0;
    rec_dataH  = 8'd0;
    out_readyH = 1'b0;
    idleCycles(3);
    checkOutput("rstValid", 32'(out_validH), 0);
    checkOutput("rstLast",  32'(out_lastH), 0);
    checkOutput("rstData",  32'(out_dataH), 0);
    checkOutput("rstBusy",  32'(busyH), 0);
    checkOutput("rstErr",   32'({err_chkH, err_lenH, err_toH, err_ovrH}), 0);

    // Receiver power-up edge carrying an SOF must not start a frame
    sys_rst_l = 1'b1;
    idleCycles(2);
    rec_dataH  = Sof;
    rec_readyH = 1'b1;
    idleCycles(6);
    checkOutput("pwrUpBusy", 32'(busyH), 0);
    checkFrame();

    // Good frame streamed on consecutive cycles
    out_readyH = 1'b1;
    txQ  = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    expQ = '{9'h011, 9'h022, 9'h133};
    sendTx(0);
    checkOutput("goodV0", 32'(out_validH), 1);
    checkOutput("goodD0", 32'(out_dataH), 32'h11);
    checkOutput("goodL0", 32'(out_lastH), 0);
    idleCycles(1);
    checkOutput("goodD1", 32'(out_dataH), 32'h22);
    checkOutput("goodL1", 32'(out_lastH), 0);
    idleCycles(1);
    checkOutput("goodD2", 32'(out_dataH), 32'h33);
    checkOutput("goodL2", 32'(out_lastH), 1);
    idleCycles(1);
    checkOutput("goodVEnd", 32'(out_validH), 0);
    checkOutput("goodBusyEnd", 32'(busyH), 0);
    waitIdle(0);
    checkFrame();

    // Checksum mismatch
    txQ = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04};
    expChk++;
    sendTx(0);
    checkOutput("badChkValid", 32'(out_validH), 0);
    waitIdle(0);
    checkFrame();

    // LEN 0 and LEN MAX_LEN+1, then a good single-byte frame
    txQ = '{8'hA5, 8'h00, 8'hA5, 8'h11, 8'hA5, 8'h01, 8'h7E, 8'h7F};
    expLen += 2;
    expQ = '{9'h17E};
    sendTx(1);
    waitIdle(1);
    checkFrame();

    // Silence until expiry
    out_readyH = 1'b1;
    txQ = '{8'hA5, 8'h02, 8'hAA};
    sendTx(0);
    idleCycles(TimeoutCyc - 1);
    checkOutput("toEarly", 32'(err_toH), 0);
    checkOutput("toBusyEarly", 32'(busyH), 1);
    idleCycles(1);
    checkOutput("toPulse", 32'(err_toH), 1);
    checkOutput("toBusy", 32'(busyH), 0);
    expTo++;
    idleCycles(1);
    checkOutput("toOnce", 32'(err_toH), 0);
    waitIdle(0);
    checkFrame();

    // Byte strobed exactly on the expiry cycle keeps the frame alive
    txQ = '{8'hA5, 8'h02, 8'hAA};
    sendTx(0);
    idleCycles(TimeoutCyc - 3);
    applyStimulus(8'hBB);
    applyStimulus(8'h13);
    expQ = '{9'h0AA, 9'h1BB};
    waitIdle(0);
    checkFrame();

    // One cycle later the frame has already timed out and the byte is ignored
    txQ = '{8'hA5, 8'h02, 8'hAA};
    sendTx(0);
    idleCycles(TimeoutCyc - 2);
    applyStimulus(8'hBB);
    expTo++;
    waitIdle(0);
    checkFrame();

    // Backpressure, then an overrun byte during delivery
    out_readyH = 1'b0;
    txQ = '{8'hA5, 8'h02, 8'h5A, 8'hC3, 8'h9B};
    sendTx(1);
    idleCycles(50);
    checkOutput("bpValid", 32'(out_validH), 1);
    checkOutput("bpData", 32'(out_dataH), 32'h5A);
    checkOutput("bpLast", 32'(out_lastH), 0);
    applyStimulus(Sof);
    expOvr++;
    checkOutput("ovrBusy", 32'(busyH), 1);
    checkOutput("ovrData", 32'(out_dataH), 32'h5A);
    expQ = '{9'h05A, 9'h1C3};
    waitIdle(1);
    checkFrame();

    // Reset during delivery drops the frame immediately
    out_readyH = 1'b0;
    txQ = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h03};
    sendTx(1);
    idleCycles(3);
    checkOutput("preRstValid", 32'(out_validH), 1);
    sys_rst_l = 1'b0;
    #1;
    checkOutput("rstMidValid", 32'(out_validH), 0);
    checkOutput("rstMidBusy", 32'(busyH), 0);
    @(posedge sys_clk); #1;
    sys_rst_l = 1'b1;
    idleCycles(2);
    out_readyH = 1'b1;
    txQ  = '{8'hA5, 8'h01, 8'hA5, 8'hA4};
    expQ = '{9'h1A5};
    sendTx(1);
    waitIdle(1);
    checkFrame();

    // Random mix of good, bad-checksum and bad-length frames with random host readiness
    for (int f = 0; f < 40; f++) begin
      r = int'($urandom_range(0, 9));
      kind = (r < 6) ? 0 : ((r < 8) ? 1 : 2);
      if (kind == 2) n = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(MaxLen + 1, 255));
      else           n = int'($urandom_range(1, MaxLen));
      if (f < 2) begin
        kind = 0;
        n    = (f == 0) ? 1 : MaxLen;
      end
      buildFrame(kind, n);
      sendTx(1);
      waitIdle(1);
      checkFrame();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/u_rx_frame_ctrl.md
Name: u_rx_frame_ctrl

Overview:
Receive-side frame controller placed directly behind the UART byte receiver (rec_dataH / rec_readyH). It detects each completed byte and parses frames of the form SOF, LEN, LEN payload bytes, CHK. Payload is staged in an internal buffer and released to the host over a valid/ready stream only after the checksum passes. It also enforces an inter-byte timeout and reports framing, checksum, timeout and overrun errors.

Parameters:
MAX_LEN, 16, maximum payload bytes per frame and buffer depth (2..64).
SOF_BYTE, 8'hA5, start-of-frame marker.
TIMEOUT_CYC, 16'd4000, maximum sys_clk cycles allowed between bytes inside one frame.

Ports:
sys_clk  in  1  clock
sys_rst_l  in  1  reset; asynchronous, active-low; clock is sys_clk
rec_dataH  in  8  byte from the UART receiver, valid at the rising edge of rec_readyH
rec_readyH  in  1  receiver ready/idle level; a rising edge marks a new byte
out_dataH  out  8  payload byte
out_validH  out  1  out_dataH is valid
out_lastH  out  1  marks the final payload byte of a frame
out_readyH  in  1  host accepts the byte when out_validH & out_readyH
busyH  out  1  a frame is being parsed or delivered
err_chkH  out  1  one-cycle pulse: checksum mismatch
err_lenH  out  1  one-cycle pulse: LEN==0 or LEN>MAX_LEN
err_toH  out  1  one-cycle pulse: inter-byte timeout
err_ovrH  out  1  one-cycle pulse: byte arrived during DELIVER and was dropped

Behaviour:
- Reset: all outputs 0, state IDLE, buffer pointers 0, timer 0, edge-detect register 0, arm flag 0.
- Byte strobe: byte_stb = rec_readyH & ~ready_q & arm.
  - ready_q holds rec_readyH delayed by one register.
  - arm is set the first cycle rec_readyH is seen high after reset, then stays set.
  - This suppresses the receiver's power-up rising edge.
  - rec_dataH is sampled in the cycle byte_stb is high. Total latency from the input edge is 1 register stage.
- State IDLE:
  - byte_stb with data==SOF_BYTE: go to LEN, clear timer, clear chk.
  - Any other byte: silently ignored.
- State LEN, on byte_stb:
  - Data 0 or >MAX_LEN: pulse err_lenH, go to IDLE.
  - Otherwise: store len, chk=data, wr_ptr=0, go to PAYLOAD.
- State PAYLOAD, on byte_stb:
  - Write buf[wr_ptr]=data, chk^=data, wr_ptr++.
  - When wr_ptr reaches len-1 on this write, go to CHECK.
- State CHECK, on byte_stb:
  - data==chk: go to DELIVER with rd_ptr=0.
  - Otherwise: pulse err_chkH, go to IDLE. Buffer contents are discarded, not cleared.
- Timeout:
  - In LEN, PAYLOAD and CHECK, the timer increments every cycle and clears on byte_stb.
  - When the timer reaches TIMEOUT_CYC-1 with no byte_stb in that cycle: pulse err_toH, go to IDLE.
  - byte_stb in the same cycle as expiry wins; no timeout is raised.
  - The timer is held at 0 in IDLE and DELIVER. Timer width is 16 bits and saturates, with no wrap.
- State DELIVER:
  - out_validH=1, out_dataH=buf[rd_ptr] (registered read, stable while valid & ~ready), out_lastH=(rd_ptr==len-1).
  - On valid&ready: rd_ptr++. On the last beat, drop out_validH the next cycle and go to IDLE.
  - The host may hold out_readyH low indefinitely; no timeout applies here.
  - byte_stb in DELIVER: pulse err_ovrH, drop the byte, stay in DELIVER. An SOF arriving here is also lost.
- Flow: back-to-back frames are allowed. The first byte_stb in IDLE after DELIVER completes is parsed normally.
- busyH = (state != IDLE).
- Error pulses are mutually exclusive and last exactly one cycle.
- Checksum: 8-bit XOR of LEN and all payload bytes.
- Pointers are $clog2(MAX_LEN) bits wide and never wrap, since len ≤ MAX_LEN.
- Reset asserted mid-frame or mid-delivery: immediate return to the reset values. Partial data is never presented.
- Unused state encodings recover to IDLE on the next clock.

Test Plan:
- Power-up: release reset, drive rec_readyH 0→1 with data 8'h00 -> no byte_stb, no error, state IDLE, busyH=0.
- Good frame A5,03,11,22,33,CHK=03^11^22^33=8'h03 with out_readyH=1 -> out stream 11,22,33 on consecutive cycles, out_lastH only with 33, no error pulses.
- Same frame with CHK=8'h04 -> err_chkH pulses once, out_validH never asserts, busyH returns to 0.
- LEN=8'h00, then LEN=MAX_LEN+1 (8'h11) -> err_lenH pulses for each, controller back in IDLE; the following good frame is delivered correctly.
- A5,02,AA, then silence for TIMEOUT_CYC cycles -> err_toH pulses exactly once at expiry, busyH=0. A byte arriving on the expiry cycle -> no timeout.
- Backpressure: good 2-byte frame with out_readyH held low 50 cycles, then a byte arrives -> err_ovrH pulses, out_dataH stays stable. Raising ready delivers both bytes in order.
